// File: rtl/addsub_arb_pkg.sv
// Shared definitions for the round-robin arbitrated adder/subtractor.
// Holds default widths, operation encodings and a width helper.
package addsub_arb_pkg;

  localparam int DEF_N    = 4;
  localparam int DEF_NREQ = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/adder_substractor.sv
// n-bit two's-complement adder/subtractor: add_n=1 computes x - y
// by inverting y and injecting a carry.
module adder_substractor #(
  parameter int n = 4
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         add_n,
  output logic [n-1:0] s,
  output logic         cout,
  output logic         overflow
);

  logic [n-1:0] yInv;
  logic [n:0]   sumFull;

  assign yInv     = y ^ {n{add_n}};
  assign sumFull  = {1'b0, x} + {1'b0, yInv} + {{n{1'b0}}, add_n};
  assign s        = sumFull[n-1:0];
  assign cout     = sumFull[n];
  assign overflow = (x[n-1] & yInv[n-1] & ~sumFull[n-1]) |
                    (~x[n-1] & ~yInv[n-1] & sumFull[n-1]);

endmodule

// File: rtl/addsub_rr_arbiter_rr_pick.sv
// Rotating priority encoder: finds the first set request at or after ptr,
// wrapping around, and reports it as one-hot and as an index.
module rr_pick
  import addsub_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] cand;

  // Scan from the farthest offset back to ptr so the nearest request wins.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
    onehot = any ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/addsub_rr_arbiter.sv
// One shared adder/subtractor serving NREQ requesters through a round-robin
// arbiter, with a registered valid/ready response carrying the winner's ID.
module addsub_rr_arbiter
  import addsub_arb_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] req_x,
  input  logic [NREQ*N-1:0] req_y,
  input  logic [NREQ-1:0]   req_add_n,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_s,
  output logic              rsp_cout,
  output logic              rsp_overflow
);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            rspValid_q, rspValid_d;
  logic [IDW-1:0]  rspId_q;
  logic [N-1:0]    rspS_q;
  logic            rspCout_q, rspOvf_q;

  logic [NREQ-1:0] pickOnehot;
  logic [IDW-1:0]  pickIdx;
  logic            pickAny;
  logic            slotFree, grantEn;
  logic [N-1:0]    selX, selY, sumS;
  logic            selAddN, sumCout, sumOvf;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) uPick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pickOnehot),
    .idx    (pickIdx),
    .any    (pickAny)
  );

  // Reset doubles as a stall so nothing is accepted while it is held.
  assign slotFree = !rspValid_q || rsp_ready;
  assign grantEn  = slotFree && pickAny && !reset;
  assign gnt      = grantEn ? pickOnehot : '0;

  always_comb begin
    selX    = '0;
    selY    = '0;
    selAddN = OP_ADD;
    for (int i = 0; i < NREQ; i++) begin
      if (pickIdx == IDW'(i)) begin
        selX    = req_x[i*N +: N];
        selY    = req_y[i*N +: N];
        selAddN = req_add_n[i];
      end
    end
  end

  adder_substractor #(.n(N)) uAddSub (
    .x        (selX),
    .y        (selY),
    .add_n    (selAddN),
    .s        (sumS),
    .cout     (sumCout),
    .overflow (sumOvf)
  );

  always_comb begin
    ptr_d      = ptr_q;
    rspValid_d = rspValid_q;
    if (grantEn) begin
      ptr_d      = (int'(pickIdx) == NREQ - 1) ? '0 : pickIdx + 1'b1;
      rspValid_d = 1'b1;
    end else if (rsp_ready) begin
      rspValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= '0;
      rspValid_q <= 1'b0;
      rspId_q    <= '0;
      rspS_q     <= '0;
      rspCout_q  <= 1'b0;
      rspOvf_q   <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      rspValid_q <= rspValid_d;
      if (grantEn) begin
        rspId_q   <= pickIdx;
        rspS_q    <= sumS;
        rspCout_q <= sumCout;
        rspOvf_q  <= sumOvf;
      end
    end
  end

  assign rsp_valid    = rspValid_q;
  assign rsp_id       = rspId_q;
  assign rsp_s        = rspS_q;
  assign rsp_cout     = rspCout_q;
  assign rsp_overflow = rspOvf_q;

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Scoreboard bench for addsub_rr_arbiter: directed scenarios plus random
// traffic checked against an arithmetic model of arbitration and results.
module tb_addsub_rr_arbiter;

  localparam int N    = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req, gnt, addN;
  logic [NREQ*N-1:0] reqX, reqY;
  logic              rspReady, rspValid, rspCout, rspOvf;
  logic [IDW-1:0]    rspId;
  logic [N-1:0]      rspS;

  typedef struct {
    int id;
    int s;
    int cout;
    int ovf;
  } expT;

  expT sbQueue[$];
  int  checks = 0;
  int  errors = 0;
  int  mPtr   = 0;
  bit  mValid = 1'b0;
  int  opX[NREQ];
  int  opY[NREQ];
  bit  opSub[NREQ];

  always #5 clk = ~clk;

  addsub_rr_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk          (clk),
    .reset        (rst),
    .req          (req),
    .req_x        (reqX),
    .req_y        (reqY),
    .req_add_n    (addN),
    .gnt          (gnt),
    .rsp_valid    (rspValid),
    .rsp_ready    (rspReady),
    .rsp_id       (rspId),
    .rsp_s        (rspS),
    .rsp_cout     (rspCout),
    .rsp_overflow (rspOvf)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference result from signed/unsigned integer arithmetic.
  function automatic expT predict(input int id, input int x, input int y, input bit sub);
    expT e;
    int raw, sx, sy, sres;
    sx = (x >= 8) ? x - 16 : x;
    sy = (y >= 8) ? y - 16 : y;
    if (sub) begin
      raw    = x - y;
      sres   = sx - sy;
      e.cout = (x >= y) ? 1 : 0;
    end else begin
      raw    = x + y;
      sres   = sx + sy;
      e.cout = (raw >= 16) ? 1 : 0;
    end
    e.id  = id;
    e.s   = ((raw % 16) + 16) % 16;
    e.ovf = (sres > 7 || sres < -8) ? 1 : 0;
    return e;
  endfunction

  task automatic setOp(input int i, input int x, input int y, input bit sub);
    opX[i]   = x;
    opY[i]   = y;
    opSub[i] = sub;
  endtask

  task automatic randomOps();
    for (int i = 0; i < NREQ; i++) begin
      setOp(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
  endtask

  // One clock cycle: drive, predict the grant at the negedge, update model.
  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic rdy,
                               output logic [NREQ-1:0] g);
    int win;
    logic [NREQ-1:0] expG;
    req      = r;
    rspReady = rdy;
    for (int i = 0; i < NREQ; i++) begin
      reqX[i*N +: N] = N'(opX[i]);
      reqY[i*N +: N] = N'(opY[i]);
      addN[i]        = opSub[i];
    end
    @(negedge clk);
    g    = gnt;
    win  = -1;
    expG = '0;
    if (!rst && (!mValid || rdy)) begin
      for (int k = 0; k < NREQ; k++) begin
        if (win < 0 && r[(mPtr + k) % NREQ]) win = (mPtr + k) % NREQ;
      end
    end
    if (win >= 0) expG[win] = 1'b1;
    checkOutput("gnt", gnt, expG);
    if (!rst) checkOutput("rsp_valid", rspValid, mValid);
    if (rst) begin
      mPtr   = 0;
      mValid = 1'b0;
      sbQueue.delete();
    end else if (win >= 0) begin
      sbQueue.push_back(predict(win, opX[win], opY[win], opSub[win]));
      mPtr   = (win + 1) % NREQ;
      mValid = 1'b1;
    end else if (rdy) begin
      mValid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    logic [NREQ-1:0] g;
    rst = 1'b1;
    applyStimulus(4'b1111, 1'b1, g);
    applyStimulus(4'b1111, 1'b1, g);
    rst = 1'b0;
  endtask

  // Monitor: every consumed response is compared against the queue head.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (!rst && rspValid === 1'b1 && rspReady === 1'b1) begin
        if (sbQueue.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rsp: got rsp_valid 1, expected no pending result");
        end else begin
          e = sbQueue.pop_front();
          checkOutput("sb_id", rspId, e.id);
          checkOutput("sb_s", rspS, e.s);
          checkOutput("sb_cout", rspCout, e.cout);
          checkOutput("sb_ovf", rspOvf, e.ovf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NREQ-1:0] g;
    expT snap;
    rst = 1'b1;
    req = '0;
    rspReady = 1'b0;
    reqX = '0;
    reqY = '0;
    addN = '0;
    for (int i = 0; i < NREQ; i++) setOp(i, 0, 0, 1'b0);

    doReset();
    checkOutput("reset_valid", rspValid, 0);
    checkOutput("reset_id", rspId, 0);
    checkOutput("reset_s", rspS, 0);
    checkOutput("reset_cout", rspCout, 0);
    checkOutput("reset_ovf", rspOvf, 0);
    applyStimulus(4'b1111, 1'b1, g);
    checkOutput("first_gnt", g, 4'b0001);

    setOp(1, 5, 3, 1'b0);
    applyStimulus(4'b0010, 1'b1, g);
    checkOutput("add_gnt", g, 4'b0010);
    checkOutput("add_valid", rspValid, 1);
    checkOutput("add_id", rspId, 1);
    checkOutput("add_s", rspS, 8);
    checkOutput("add_cout", rspCout, 0);
    checkOutput("add_ovf", rspOvf, 1);

    setOp(2, 3, 5, 1'b1);
    applyStimulus(4'b0100, 1'b1, g);
    checkOutput("sub2_s", rspS, 14);
    checkOutput("sub2_cout", rspCout, 0);
    checkOutput("sub2_ovf", rspOvf, 0);
    setOp(3, 5, 3, 1'b1);
    applyStimulus(4'b1000, 1'b1, g);
    checkOutput("sub3_s", rspS, 2);
    checkOutput("sub3_cout", rspCout, 1);
    setOp(0, 8, 1, 1'b1);
    applyStimulus(4'b0001, 1'b1, g);
    checkOutput("sub0_s", rspS, 7);
    checkOutput("sub0_ovf", rspOvf, 1);

    doReset();
    for (int k = 0; k < 6; k++) begin
      randomOps();
      applyStimulus(4'b1111, 1'b1, g);
      checkOutput("rr_gnt", g, 1 << (k % NREQ));
      checkOutput("rr_id", rspId, k % NREQ);
    end

    snap = predict(1, opX[1], opY[1], opSub[1]);
    for (int k = 0; k < 3; k++) begin
      randomOps();
      applyStimulus(4'b0101, 1'b0, g);
      checkOutput("stall_gnt", g, 0);
      checkOutput("stall_valid", rspValid, 1);
      checkOutput("stall_id", rspId, 1);
      checkOutput("stall_s", rspS, snap.s);
      checkOutput("stall_cout", rspCout, snap.cout);
    end
    applyStimulus(4'b0101, 1'b1, g);
    checkOutput("release_gnt", g, 4'b0100);

    applyStimulus(4'b0010, 1'b1, g);
    rst = 1'b1;
    applyStimulus(4'b0101, 1'b1, g);
    rst = 1'b0;
    checkOutput("midreset_valid", rspValid, 0);
    applyStimulus(4'b0101, 1'b1, g);
    checkOutput("midreset_gnt", g, 4'b0001);

    for (int c = 0; c < 300; c++) begin
      randomOps();
      rst = ($urandom_range(0, 99) == 0);
      applyStimulus(NREQ'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7), g);
    end
    rst = 1'b0;

    applyStimulus(4'b0000, 1'b1, g);
    applyStimulus(4'b0000, 1'b1, g);
    checkOutput("sb_empty", sbQueue.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_rr_arbiter.md
# addsub_rr_arbiter

- Shares one n-bit adder/subtractor datapath among `NREQ` requesters.
- A round-robin arbiter accepts at most one operation per cycle.
- The result is registered with the winner's ID and presented on a single response channel with valid/ready backpressure.
- Sits between several ALU-op producers and one result consumer, so the adder does not have to be replicated.

## Interface
- `N`, default 4: operand/result width in bits.
- `NREQ`, default 4: number of requesters, ≥2.
- `IDW`, default `$clog2(NREQ)`: width of `rsp_id`.

Ports:
- `clk` in 1: the single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `req` in `NREQ`: `req[i]` means requester i has an operation pending.
- `req_x` in `NREQ*N`: operand x of requester i in bits `[i*N +: N]`.
- `req_y` in `NREQ*N`: operand y of requester i, same packing.
- `req_add_n` in `NREQ`: 0 = add, 1 = subtract (x − y), per requester.
- `gnt` out `NREQ`: one-hot or zero, combinational; `gnt[i]` means the op is accepted at this edge.
- `rsp_valid` out 1: the response register holds a result.
- `rsp_ready` in 1: the consumer accepts the result at this edge.
- `rsp_id` out `IDW`: index of the requester that owns the result.
- `rsp_s` out `N`: sum/difference, modulo 2^N.
- `rsp_cout` out 1: carry out of the MSB (for subtract, 1 = no borrow).
- `rsp_overflow` out 1: two's-complement signed overflow.

## Operation
- **Request handshake.** Requester i holds `req[i]` and its operands stable until it sees `gnt[i]`=1. The transfer completes on that rising edge, and the requester may change its operands or drop `req` on the next cycle.
- **Slot free.** `slot_free = !rsp_valid || rsp_ready`.
  - `gnt` is nonzero only when `slot_free` and at least one `req` bit are set.
- **Winner selection.** The winner is the first set `req` bit found scanning i = ptr, ptr+1, …, wrapping modulo `NREQ`.
- **Pointer update.** Pointer `ptr` (IDW bits) becomes winner+1 mod `NREQ` on every grant, and holds when there is no grant.
  - This gives strict round-robin: a continuously asserted requester waits at most `NREQ`−1 grants.
- **Datapath.** The granted operands go through the adder/subtractor:
  - y' = y XOR {N{add_n}}, cin = add_n.
  - s = (x + y' + cin) mod 2^N; cout = bit N of that sum.
  - overflow = (x[N-1] & y'[N-1] & ~s[N-1]) | (~x[N-1] & ~y'[N-1] & s[N-1]).
- **Response register.** Loads `rsp_s`, `rsp_cout`, `rsp_overflow` and `rsp_id` on a grant.
- **`rsp_valid` next value:**
  - grant: 1;
  - else `rsp_ready`: 0;
  - else: hold.
- **Simultaneous drain and grant.** When `rsp_ready`=1 while `rsp_valid`=1 and a new op is granted in the same cycle, the old result is consumed and the new one is loaded; there is no bubble.
- **Stall.** While `rsp_valid`=1 and `rsp_ready`=0:
  - `gnt`=0;
  - all rsp fields hold stable;
  - `ptr` holds.
- **Single requester.** With one requester the pointer still advances, but the same requester re-wins on every grant.

## Timing
- **Reset values.**
  - `rsp_valid`=0, `rsp_id`=0, `rsp_s`=0, `rsp_cout`=0, `rsp_overflow`=0, `ptr`=0.
  - `gnt` is 0 while `reset`=1: reset forces a stall regardless of `req`.
- **Reset mid-operation.** A pending result is discarded without being presented. After reset deasserts, the first grant goes to the lowest-indexed active requester.
- **Latency.** Exactly 1 cycle from the grant edge to `rsp_valid`=1.
- **Throughput.** 1 op per cycle while `rsp_ready`=1.
- **Combinational path.** `gnt` depends combinationally on `req`, `ptr`, `rsp_valid` and `rsp_ready`. There is no combinational path from `req_x`/`req_y` to any output.
- **Ignored inputs.** Operands of non-granted requesters are don't-care.

## Structure
- **Shared package `addsub_arb_pkg`.**
  - The `clog2` function.
  - `OP_ADD`=1'b0 and `OP_SUB`=1'b1.
  - Default `N`/`NREQ`.
- **Sub-modules.**
  - `rr_pick #(NREQ)`: combinational rotate-priority-encode. Inputs `req`, `ptr`; outputs `onehot`, `idx`, `any`.
  - One instance of the team's existing n-bit adder/subtractor (`adder_substractor #(.n(N))`), fed by the granted-operand mux. Its `overflow` output is used directly.
- **Top level.** Mux, `ptr`, and the response register, approximately 150–250 lines.

## Test plan
- **Reset.** Assert `reset` for 2 cycles with `req`=4'b1111 → `gnt`=0; after reset, all rsp outputs are 0 and `rsp_valid`=0; the first grant is `gnt`=4'b0001.
- **Add with overflow.** `req`=4'b0010, x=5, y=3, add_n=0, `rsp_ready`=1 → `gnt`=4'b0010 that cycle; next cycle `rsp_valid`=1, `rsp_id`=1, `rsp_s`=8, `rsp_cout`=0, `rsp_overflow`=1.
- **Subtract.**
  - Requester 2: x=3, y=5, add_n=1 → `rsp_s`=14, `rsp_cout`=0, `rsp_overflow`=0.
  - Requester 3: x=5, y=3, add_n=1 → `rsp_s`=2, `rsp_cout`=1.
  - Requester 0: x=8, y=1, add_n=1 → `rsp_s`=7, `rsp_overflow`=1.
- **Round-robin.** `req`=4'b1111 held, `rsp_ready`=1 → grants 0,1,2,3,0,1 on consecutive cycles; `rsp_id` follows one cycle later with no gaps.
- **Backpressure.** Result pending, `rsp_ready`=0 for 3 cycles with `req`=4'b0101 → `gnt`=0 and rsp fields stable throughout; raise `rsp_ready` → a grant occurs in that same cycle to the next index at or after `ptr`.
- **Reset mid-stream.** `ptr`=2, `rsp_valid`=1, `req`=4'b0101, pulse `reset` → next cycle `rsp_valid`=0; the first post-reset grant is `gnt`=4'b0001.
